// File: rtl/mux_arb_n.sv
// Registered N-channel bus multiplexer with round-robin or fixed-priority
// arbitration and a valid/ready handshake on every port.
module mux_arb_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned RR    = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NCH-1:0]                          in_valid,
  input  logic [NCH*WIDTH-1:0]                    in_data,
  output logic [NCH-1:0]                          in_ready,
  output logic                                    out_valid,
  output logic [WIDTH-1:0]                        out_data,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_sel,
  input  logic                                    out_ready
);

  localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_sel;
  logic [SELW-1:0]  r_ptr;

  logic             w_load;
  logic             w_found;
  logic [SELW-1:0]  w_win;
  logic [SELW-1:0]  w_idx;
  logic [WIDTH-1:0] w_data;
  logic [SELW-1:0]  w_ptr_next;

  assign w_load = ~r_valid | out_ready;

  // Scan starts at ptr in round-robin mode, at index 0 in fixed-priority mode.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      w_idx = (RR != 0) ? SELW'((32'(r_ptr) + k) % NCH) : SELW'(k);
      if (!w_found && in_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (SELW'(k) == w_win) begin
        w_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_next = (w_win == SELW'(NCH - 1)) ? '0 : w_win + 1'b1;

  // Gated by rst so nothing is granted during the reset cycle.
  assign in_ready = (!rst && w_load && w_found) ? (NCH'(1) << w_win) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_sel   <= w_win;
        if (RR != 0) begin
          r_ptr <= w_ptr_next;
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: one round-robin and one fixed-priority
// instance share stimulus; expectations are hand-computed per vector.
module tb_mux_arb_n;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NCH   = 4;
  localparam logic [31:0] D     = 32'h1312_1110;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic [3:0]  rr_ready, fp_ready;
  logic        rr_valid, fp_valid;
  logic [7:0]  rr_data,  fp_data;
  logic [1:0]  rr_sel,   fp_sel;

  int errors = 0;
  int checks = 0;

  mux_arb_n #(.WIDTH(WIDTH), .NCH(NCH), .RR(1)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_ready), .out_valid(rr_valid), .out_data(rr_data),
    .out_sel(rr_sel), .out_ready(out_ready)
  );

  mux_arb_n #(.WIDTH(WIDTH), .NCH(NCH), .RR(0)) u_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(fp_ready), .out_valid(fp_valid), .out_data(fp_data),
    .out_sel(fp_sel), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  v;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  er_rr;
    logic [3:0]  er_fp;
    logic        ev_rr;
    logic [7:0]  ed_rr;
    logic [1:0]  es_rr;
    logic        ev_fp;
    logic [7:0]  ed_fp;
    logic [1:0]  es_fp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  vec_t vecs[$];

  task automatic add(input string n, input logic r, input logic [3:0] v, input logic [31:0] d,
                     input logic o, input logic [3:0] err, input logic [3:0] efp,
                     input logic evr, input logic [7:0] edr, input logic [1:0] esr,
                     input logic evf, input logic [7:0] edf, input logic [1:0] esf);
    vec_t t;
    t.name = n; t.rst = r; t.v = v; t.d = d; t.ordy = o;
    t.er_rr = err; t.er_fp = efp;
    t.ev_rr = evr; t.ed_rr = edr; t.es_rr = esr;
    t.ev_fp = evf; t.ed_fp = edf; t.es_fp = esf;
    vecs.push_back(t);
  endtask

  int gcnt_rr[4];
  int gcnt_fp[4];

  initial begin
    rst = 1'b1; in_valid = 4'hF; in_data = D; out_ready = 1'b1;

    // name        rst v     data           ordy rdy_rr rdy_fp  v  data   sel   v  data   sel
    add("reset0",   1, 4'hF, D,             1, 4'h0, 4'h0,   0, 8'h00, 0,    0, 8'h00, 0);
    add("reset1",   1, 4'hF, D,             1, 4'h0, 4'h0,   0, 8'h00, 0,    0, 8'h00, 0);
    add("single",   0, 4'h4, 32'h13A5_1110, 1, 4'h4, 4'h4,   1, 8'hA5, 2,    1, 8'hA5, 2);
    add("idle",     0, 4'h0, D,             1, 4'h0, 4'h0,   0, 8'hA5, 2,    0, 8'hA5, 2);
    add("reset2",   1, 4'hF, D,             1, 4'h0, 4'h0,   0, 8'h00, 0,    0, 8'h00, 0);
    add("rot0",     0, 4'hF, D,             1, 4'h1, 4'h1,   1, 8'h10, 0,    1, 8'h10, 0);
    add("rot1",     0, 4'hF, D,             1, 4'h2, 4'h1,   1, 8'h11, 1,    1, 8'h10, 0);
    add("rot2",     0, 4'hF, D,             1, 4'h4, 4'h1,   1, 8'h12, 2,    1, 8'h10, 0);
    add("rot3",     0, 4'hF, D,             1, 4'h8, 4'h1,   1, 8'h13, 3,    1, 8'h10, 0);
    add("rot4",     0, 4'hF, D,             1, 4'h1, 4'h1,   1, 8'h10, 0,    1, 8'h10, 0);
    add("rot5",     0, 4'hF, D,             1, 4'h2, 4'h1,   1, 8'h11, 1,    1, 8'h10, 0);
    add("rot6",     0, 4'hF, D,             1, 4'h4, 4'h1,   1, 8'h12, 2,    1, 8'h10, 0);
    add("rot7",     0, 4'hF, D,             1, 4'h8, 4'h1,   1, 8'h13, 3,    1, 8'h10, 0);
    add("drop0",    0, 4'hE, D,             1, 4'h2, 4'h2,   1, 8'h11, 1,    1, 8'h11, 1);
    add("stall0",   0, 4'h3, D,             0, 4'h0, 4'h0,   1, 8'h11, 1,    1, 8'h11, 1);
    add("stall1",   0, 4'h3, D,             0, 4'h0, 4'h0,   1, 8'h11, 1,    1, 8'h11, 1);
    add("stall2",   0, 4'h3, D,             0, 4'h0, 4'h0,   1, 8'h11, 1,    1, 8'h11, 1);
    add("unstall",  0, 4'h3, D,             1, 4'h1, 4'h1,   1, 8'h10, 0,    1, 8'h10, 0);
    add("ptrkept",  0, 4'h3, D,             1, 4'h2, 4'h1,   1, 8'h11, 1,    1, 8'h10, 0);
    add("load3c",   0, 4'h1, 32'h1312_113C, 1, 4'h1, 4'h1,   1, 8'h3C, 0,    1, 8'h3C, 0);
    add("hold3c",   0, 4'h0, D,             0, 4'h0, 4'h0,   1, 8'h3C, 0,    1, 8'h3C, 0);
    add("midrst",   1, 4'h3, D,             0, 4'h0, 4'h0,   0, 8'h00, 0,    0, 8'h00, 0);
    add("postrst",  0, 4'h9, D,             1, 4'h1, 4'h1,   1, 8'h10, 0,    1, 8'h10, 0);
    add("drain",    0, 4'h0, D,             1, 4'h0, 4'h0,   0, 8'h10, 0,    0, 8'h10, 0);

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; in_valid = vecs[i].v; in_data = vecs[i].d; out_ready = vecs[i].ordy;
      #2;
      chk({vecs[i].name, ".rr_in_ready"}, 32'(rr_ready), 32'(vecs[i].er_rr));
      chk({vecs[i].name, ".fp_in_ready"}, 32'(fp_ready), 32'(vecs[i].er_fp));
      @(posedge clk); #1;
      chk({vecs[i].name, ".rr_out_valid"}, 32'(rr_valid), 32'(vecs[i].ev_rr));
      chk({vecs[i].name, ".rr_out_data"},  32'(rr_data),  32'(vecs[i].ed_rr));
      chk({vecs[i].name, ".rr_out_sel"},   32'(rr_sel),   32'(vecs[i].es_rr));
      chk({vecs[i].name, ".fp_out_valid"}, 32'(fp_valid), 32'(vecs[i].ev_fp));
      chk({vecs[i].name, ".fp_out_data"},  32'(fp_data),  32'(vecs[i].ed_fp));
      chk({vecs[i].name, ".fp_out_sel"},   32'(fp_sel),   32'(vecs[i].es_fp));
    end

    // Fairness: 12 cycles of full contention, no backpressure.
    for (int c = 0; c < 4; c++) begin
      gcnt_rr[c] = 0;
      gcnt_fp[c] = 0;
    end
    rst = 1'b0; in_valid = 4'hF; in_data = D; out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      #2;
      for (int c = 0; c < 4; c++) begin
        if (rr_ready[c]) gcnt_rr[c]++;
        if (fp_ready[c]) gcnt_fp[c]++;
      end
      @(posedge clk); #1;
      chk("fair.rr_out_valid", 32'(rr_valid), 32'd1);
    end
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("fair.rr_grants_ch%0d", c), 32'(gcnt_rr[c]), 32'd3);
      chk($sformatf("fair.fp_grants_ch%0d", c), 32'(gcnt_fp[c]), (c == 0) ? 32'd12 : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
